// File: rtl/prbs31_checker.sv
// prbs31_checker
//   Receive-side PRBS31 (x^31 + x^28 + 1) checker. It seeds a local LFSR from
//   the incoming serial stream and confirms the pattern before declaring lock.
//   While locked it counts checked bits and mismatched bits. Too many errors
//   inside one window drop lock and restart seeding.
//
// Ports
//   clk_25G    in   bit clock, all logic on posedge
//   rst        in   asynchronous reset, active-high
//   data_in    in   received serial bit
//   data_vld   in   data_in valid this cycle; the checker advances only then
//   clr_cnt    in   synchronous clear of err_cnt and bit_cnt
//   locked     out  pattern locked
//   err_pulse  out  one-cycle pulse per mismatched bit while locked
//   err_cnt    out  saturating mismatch count while locked
//   bit_cnt    out  saturating checked-bit count while locked
//
// State  | Meaning
// SEED   | shifting 31 received bits into the LFSR
// VERIFY | free-running LFSR, counting consecutive matches towards lock
// LOCKED | free-running LFSR, counting bits and errors, watching error window

module prbs31_checker #(
    parameter int LOCK_CNT   = 64,
    parameter int WIN_LEN    = 128,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk_25G,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN_LEN + 1);
    localparam int WERR_W = $clog2(ERR_THRESH + 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [30:0]       sr;
    logic [4:0]        seed_cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [WERR_W-1:0] win_err;

    logic              pred;
    logic              mismatch;
    logic [30:0]       sr_seed;
    logic [WERR_W-1:0] win_err_next;

    always_comb begin
        pred         = sr[30] ^ sr[27];
        mismatch     = data_in ^ pred;
        sr_seed      = {sr[29:0], data_in};
        win_err_next = win_err + WERR_W'(mismatch);
    end

    always_ff @(posedge clk_25G or posedge rst) begin
        if (rst) begin
            state     <= SEED;
            sr        <= '0;
            seed_cnt  <= '0;
            good_cnt  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (data_vld) begin
                case (state)
                    SEED: begin
                        sr <= sr_seed;
                        if (seed_cnt == 5'd30) begin
                            seed_cnt <= '0;
                            good_cnt <= '0;
                            // An all-zero seed is the LFSR's lock-up state; keep seeding.
                            if (sr_seed != '0)
                                state <= VERIFY;
                        end else begin
                            seed_cnt <= seed_cnt + 5'd1;
                        end
                    end
                    VERIFY: begin
                        sr <= {sr[29:0], pred};
                        if (mismatch) begin
                            state    <= SEED;
                            seed_cnt <= '0;
                            good_cnt <= '0;
                        end else if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                        end
                    end
                    LOCKED: begin
                        // Data is never ingested here, so one flipped bit costs one error.
                        sr        <= {sr[29:0], pred};
                        err_pulse <= mismatch;
                        // Threshold is tested before the window wrap so it wins on the same bit.
                        if (win_err_next == WERR_W'(ERR_THRESH)) begin
                            state    <= SEED;
                            locked   <= 1'b0;
                            seed_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_err_next;
                        end
                    end
                    default: begin
                        state    <= SEED;
                        locked   <= 1'b0;
                        seed_cnt <= '0;
                    end
                endcase
            end

            if (clr_cnt) begin
                err_cnt <= '0;
                bit_cnt <= '0;
            end else if (data_vld && state == LOCKED) begin
                if (bit_cnt != '1)
                    bit_cnt <= bit_cnt + CNT_W'(1);
                if (mismatch && err_cnt != '1)
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prbs31_checker.sv
module tb_prbs31_checker;

    localparam int LOCK_CNT   = 64;
    localparam int WIN_LEN    = 128;
    localparam int ERR_THRESH = 8;
    localparam int SMALL_MAX  = 15;

    localparam int SRC_ZERO = 0;
    localparam int SRC_ONE  = 1;
    localparam int SRC_PRBS = 2;

    logic        clk_25G = 1'b0;
    logic        rst;
    logic        data_in;
    logic        data_vld;
    logic        clr_cnt;
    logic        locked, err_pulse;
    logic [31:0] err_cnt, bit_cnt;
    logic        locked_s, err_pulse_s;
    logic [3:0]  err_cnt_s, bit_cnt_s;

    prbs31_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .ERR_THRESH(ERR_THRESH), .CNT_W(32)) dut (
        .clk_25G(clk_25G), .rst(rst), .data_in(data_in), .data_vld(data_vld), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt));

    prbs31_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .ERR_THRESH(ERR_THRESH), .CNT_W(4)) dut_s (
        .clk_25G(clk_25G), .rst(rst), .data_in(data_in), .data_vld(data_vld), .clr_cnt(clr_cnt),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s), .bit_cnt(bit_cnt_s));

    always #2 clk_25G = ~clk_25G;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks the last 31 reference bits in a queue (oldest first),
    // phase as SEED=0 / VERIFY=1 / LOCKED=2, and unbounded counts.
    int     m_mode, m_nseed, m_good, m_win, m_werr;
    bit     m_q[$];
    longint m_ecnt, m_bcnt;
    bit     m_pulse;

    task automatic model_reset();
        m_mode = 0; m_nseed = 0; m_good = 0; m_win = 0; m_werr = 0;
        m_ecnt = 0; m_bcnt = 0; m_pulse = 0;
        m_q.delete();
        for (int i = 0; i < 31; i++) m_q.push_back(1'b0);
    endtask

    task automatic model_step(input bit d, input bit v, input bit c);
        bit p, mis, any_one, was_locked;
        mis = 0;
        was_locked = (m_mode == 2);
        m_pulse = 0;
        if (v) begin
            if (m_mode == 0) begin
                m_q.push_back(d);
                void'(m_q.pop_front());
                m_nseed++;
                if (m_nseed == 31) begin
                    m_nseed = 0;
                    any_one = 0;
                    foreach (m_q[i]) any_one |= m_q[i];
                    if (any_one) begin m_mode = 1; m_good = 0; end
                end
            end else begin
                // next bit of x^31+x^28+1: s[n] = s[n-31] ^ s[n-28]
                p = m_q[0] ^ m_q[3];
                m_q.push_back(p);
                void'(m_q.pop_front());
                mis = (d != p);
                if (m_mode == 1) begin
                    if (mis) begin
                        m_mode = 0; m_nseed = 0; m_good = 0;
                    end else begin
                        m_good++;
                        if (m_good == LOCK_CNT) begin
                            m_mode = 2; m_good = 0; m_win = 0; m_werr = 0;
                        end
                    end
                end else begin
                    m_pulse = mis;
                    m_werr += int'(mis);
                    if (m_werr == ERR_THRESH) begin
                        m_mode = 0; m_nseed = 0; m_win = 0; m_werr = 0;
                    end else begin
                        m_win++;
                        if (m_win == WIN_LEN) begin m_win = 0; m_werr = 0; end
                    end
                end
            end
        end
        if (c) begin
            m_ecnt = 0; m_bcnt = 0;
        end else if (v && was_locked) begin
            m_bcnt++;
            if (mis) m_ecnt++;
        end
    endtask

    function automatic longint sat(input longint x);
        return (x > SMALL_MAX) ? SMALL_MAX : x;
    endfunction

    // Transmit-side PRBS31 stream generator.
    bit g_q[$];

    task automatic gen_seed();
        g_q.delete();
        for (int i = 0; i < 31; i++) g_q.push_back(bit'($urandom_range(0, 1)));
        g_q[7] = 1'b1;
    endtask

    function automatic bit gen_next();
        bit b;
        b = g_q[0] ^ g_q[3];
        g_q.push_back(b);
        void'(g_q.pop_front());
        return b;
    endfunction

    int tog_cnt = 0;

    task automatic step(input bit d, input bit v, input bit c);
        data_in = d; data_vld = v; clr_cnt = c;
        model_step(d, v, c);
        @(posedge clk_25G);
        #1;
        check("locked", locked, m_mode == 2);
        check("err_pulse", err_pulse, m_pulse);
        check("err_cnt", err_cnt, m_ecnt);
        check("bit_cnt", bit_cnt, m_bcnt);
        check("locked_s", locked_s, m_mode == 2);
        check("err_pulse_s", err_pulse_s, m_pulse);
        check("err_cnt_s", err_cnt_s, sat(m_ecnt));
        check("bit_cnt_s", bit_cnt_s, sat(m_bcnt));
    endtask

    // Valid PRBS bit, optionally flipped; junk data when not valid.
    task automatic prbs_step(input bit v, input bit flip, input bit c);
        bit d;
        if (v) d = gen_next() ^ flip;
        else   d = bit'($urandom_range(0, 1));
        step(d, v, c);
    endtask

    task automatic clean_bits(input int n);
        for (int i = 0; i < n; i++) prbs_step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; data_vld = 1'b0; data_in = 1'b0; clr_cnt = 1'b0;
        repeat (10) @(posedge clk_25G);
        #1;
        check("rst_locked", locked, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        rst = 1'b0;
        model_reset();
        gen_seed();
        tog_cnt = 0;
    endtask

    typedef struct {
        bit     do_rst;
        int     n;
        int     src;
        bit     tog;
        bit     exp_locked;
        longint exp_err;
        longint exp_bit;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 500,  SRC_ZERO, 1'b0, 1'b0, 0, 0};
        vecs[1] = '{1'b1, 300,  SRC_ONE,  1'b0, 1'b0, 0, 0};
        vecs[2] = '{1'b1, 94,   SRC_PRBS, 1'b0, 1'b0, 0, 0};
        vecs[3] = '{1'b0, 1,    SRC_PRBS, 1'b0, 1'b1, 0, 0};
        vecs[4] = '{1'b0, 1000, SRC_PRBS, 1'b0, 1'b1, 0, 1000};
        vecs[5] = '{1'b1, 188,  SRC_PRBS, 1'b1, 1'b0, 0, 0};
        vecs[6] = '{1'b0, 1,    SRC_PRBS, 1'b1, 1'b1, 0, 0};
        vecs[7] = '{1'b0, 200,  SRC_PRBS, 1'b1, 1'b1, 0, 100};

        rst = 1'b1; data_in = 1'b0; data_vld = 1'b0; clr_cnt = 1'b0;
        model_reset();

        foreach (vecs[k]) begin
            if (vecs[k].do_rst) do_reset();
            for (int i = 0; i < vecs[k].n; i++) begin
                bit v;
                v = vecs[k].tog ? (tog_cnt % 2 == 0) : 1'b1;
                tog_cnt++;
                if (vecs[k].src == SRC_PRBS)      prbs_step(v, 1'b0, 1'b0);
                else if (!v)                      step(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
                else if (vecs[k].src == SRC_ONE)  step(1'b1, 1'b1, 1'b0);
                else                              step(1'b0, 1'b1, 1'b0);
            end
            check($sformatf("vec%0d_locked", k), locked, vecs[k].exp_locked);
            check($sformatf("vec%0d_err_cnt", k), err_cnt, vecs[k].exp_err);
            check($sformatf("vec%0d_bit_cnt", k), bit_cnt, vecs[k].exp_bit);
        end

        // Single flipped bit after lock.
        do_reset();
        clean_bits(95);
        check("t2_locked", locked, 1);
        clean_bits(499);
        prbs_step(1'b1, 1'b1, 1'b0);
        check("t2_pulse_hi", err_pulse, 1);
        check("t2_err_cnt", err_cnt, 1);
        prbs_step(1'b1, 1'b0, 1'b0);
        check("t2_pulse_lo", err_pulse, 0);
        check("t2_still_locked", locked, 1);
        check("t2_bit_cnt", bit_cnt, 501);

        // Eight flips within one window drop lock; relock 95 clean bits later.
        do_reset();
        clean_bits(95);
        for (int i = 0; i <= 84; i++) prbs_step(1'b1, (i % 12) == 0, 1'b0);
        check("t3_unlocked", locked, 0);
        check("t3_err_cnt", err_cnt, 8);
        clean_bits(94);
        check("t3_not_yet", locked, 0);
        clean_bits(1);
        check("t3_relocked", locked, 1);
        check("t3_err_held", err_cnt, 8);

        // Clear on the same cycle as an error.
        clean_bits(20);
        prbs_step(1'b1, 1'b1, 1'b1);
        check("t6_pulse", err_pulse, 1);
        check("t6_err_cnt", err_cnt, 0);
        check("t6_bit_cnt", bit_cnt, 0);
        prbs_step(1'b1, 1'b0, 1'b0);
        check("t6_bit_after", bit_cnt, 1);

        // Saturation on the narrow instance: 6 errors in each of three windows.
        do_reset();
        clean_bits(95);
        for (int i = 0; i < 384; i++) begin
            int r;
            r = i % WIN_LEN;
            prbs_step(1'b1, (r >= 10 && r <= 60 && r % 10 == 0), 1'b0);
        end
        check("sat_locked", locked, 1);
        check("sat_err_cnt", err_cnt, 18);
        check("sat_bit_cnt", bit_cnt, 384);
        check("sat_err_cnt_s", err_cnt_s, SMALL_MAX);
        check("sat_bit_cnt_s", bit_cnt_s, SMALL_MAX);

        // Asynchronous reset while locked, between clock edges.
        #1;
        rst = 1'b1;
        #0.5;
        check("arst_locked", locked, 0);
        check("arst_err_cnt", err_cnt, 0);
        check("arst_bit_cnt", bit_cnt, 0);
        check("arst_err_cnt_s", err_cnt_s, 0);
        do_reset();

        // Randomised traffic: varying valid density, error rate and occasional clears.
        for (int chunk = 0; chunk < 40; chunk++) begin
            int rate, vprob;
            case ($urandom_range(0, 5))
                0, 1:    rate = 0;
                2:       rate = 300;
                3:       rate = 60;
                4:       rate = 25;
                default: rate = 6;
            endcase
            vprob = $urandom_range(40, 100);
            for (int i = 0; i < 500; i++) begin
                bit v, f, c;
                v = ($urandom_range(0, 99) < vprob);
                f = (rate > 0) && ($urandom_range(0, rate - 1) == 0);
                c = ($urandom_range(0, 399) == 0);
                prbs_step(v, f, c);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
